vppm_modulator_tx: RTL and testbench

//  VPPM transmitter for the optical link: it serializes parallel words into variable-pulse-position symbols.

---
 rtl/vppm_pkg.sv | 26 ++
 rtl/vppm_modulator_tx_if.sv | 11 +
 rtl/vppm_symbol_gen.sv | 80 ++++++++
 rtl/vppm_modulator_tx.sv | 132 +++++++++++++
 tb/tb_vppm_modulator_tx.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vppm_pkg.sv
// Shared types for the VPPM transmitter: the frame FSM states, the symbol shapes and the
// minimum legal symbol period.
package vppm_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        DATA     = 3'd2,
        PARITY   = 3'd3,
        GAP      = 3'd4
    } state_t;

    // A bit0/preamble symbol is high at its start. A bit1 symbol is high at its end.
    // SYM_OFF holds the line low (gap).
    typedef logic [1:0] shape_t;
    localparam shape_t SYM_ZERO = 2'd0;
    localparam shape_t SYM_ONE  = 2'd1;
    localparam shape_t SYM_OFF  = 2'd2;

    localparam int T_MIN = 2;

    function automatic shape_t bit_shape(input logic b);
        return b ? SYM_ONE : SYM_ZERO;
    endfunction

endpackage

// File: rtl/vppm_modulator_tx_if.sv
// Word handshake between the framing logic (master) and the VPPM transmitter (slave).
interface vppm_modulator_tx_if #(
    parameter int DATA_W = 8
) ();
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/vppm_symbol_gen.sv
// Symbol timing engine: the clamped T/W shadows, the in-symbol counter, the registered line
// level and the symbol-boundary strobe.
module vppm_symbol_gen
    import vppm_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             run,
    input  logic             last,
    input  shape_t           shape,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] width,
    output logic             line_level,
    output logic             sym_strobe,
    output logic             sym_end
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] t_s;
    logic [CNT_W-1:0] w_s;
    logic [CNT_W-1:0] t_clamp;
    logic [CNT_W-1:0] w_clamp;

    // Clamping keeps W within 1..T-1, so every symbol has both a high part and a low part.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        t_clamp = (period < CNT_W'(T_MIN)) ? CNT_W'(T_MIN) : period;
        w_clamp = width;
        if (width == '0) begin
            w_clamp = CNT_W'(1);
        end else if (width >= t_clamp) begin
            w_clamp = t_clamp - CNT_W'(1);
        end
    end

    function automatic logic level(input shape_t s, input logic [CNT_W-1:0] c,
                                   input logic [CNT_W-1:0] t, input logic [CNT_W-1:0] w);
        case (s)
            SYM_ZERO: level = (c < w);
            SYM_ONE:  level = (c >= t - w);
            default:  level = 1'b0;
        endcase
    endfunction

    assign sym_end = run && (cnt == t_s - CNT_W'(1));

    // The line is computed one cycle ahead from the next count, so vppm_out comes straight from a flop.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every flop samples its pre-edge inputs.
        if (!rst_n) begin
            cnt        <= '0;
            t_s        <= CNT_W'(T_MIN);
            w_s        <= CNT_W'(1);
            line_level <= 1'b0;
            sym_strobe <= 1'b0;
        end else if (start) begin
            t_s        <= t_clamp;
            w_s        <= w_clamp;
            cnt        <= '0;
            sym_strobe <= 1'b1;
            line_level <= level(shape, '0, t_clamp, w_clamp);
        end else if (sym_end) begin
            cnt        <= '0;
            sym_strobe <= !last;
            line_level <= !last && level(shape, '0, t_s, w_s);
        end else if (run) begin
            cnt        <= cnt + CNT_W'(1);
            sym_strobe <= 1'b0;
            line_level <= level(shape, cnt + CNT_W'(1), t_s, w_s);
        end else begin
            cnt        <= '0;
            sym_strobe <= 1'b0;
            line_level <= 1'b0;
        end
    end

endmodule

// File: rtl/vppm_modulator_tx.sv
// VPPM transmitter. It sends a preamble, then DATA_W bits MSB first, then one low gap symbol.
// Define VPPM_PARITY_EN to insert an even-parity symbol between the data bits and the gap.
module vppm_modulator_tx
    import vppm_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int PREAMBLE_LEN = 7,
    parameter int CNT_W        = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CNT_W-1:0]   symbol_period,
    input  logic [CNT_W-1:0]   pulse_width,
    vppm_modulator_tx_if.slave tx,
    output logic               vppm_out,
    output logic               busy,
    output logic               sym_strobe
);

    localparam int PRE_W = $clog2(PREAMBLE_LEN + 1);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_LEN - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_shift;
    logic [PRE_W-1:0]  pre_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic              accept;
    logic              sym_end;
    shape_t            shape;
`ifdef VPPM_PARITY_EN
    logic              parity;
`endif

    assign tx.tx_ready = rst_n && (state == IDLE);
    assign accept      = tx.tx_valid && tx.tx_ready;
    assign busy        = (state != IDLE);
    assign shreg_shift = shreg << 1;

    // Shape of the symbol that will be on the line next cycle; it changes only at sym_end.
    always_comb begin
        shape = SYM_OFF;
        unique case (state)
            IDLE:     shape = SYM_ZERO;
            PREAMBLE: shape = (sym_end && pre_cnt == PRE_LAST) ? bit_shape(shreg[DATA_W-1]) : SYM_ZERO;
            DATA: begin
                if (!sym_end) begin
                    shape = bit_shape(shreg[DATA_W-1]);
                end else if (bit_cnt != BIT_LAST) begin
                    shape = bit_shape(shreg_shift[DATA_W-1]);
`ifdef VPPM_PARITY_EN
                end else begin
                    shape = bit_shape(parity ^ shreg[DATA_W-1]);
`endif
                end
            end
`ifdef VPPM_PARITY_EN
            PARITY:   shape = sym_end ? SYM_OFF : bit_shape(parity);
`endif
            default:  shape = SYM_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            pre_cnt <= '0;
            bit_cnt <= '0;
`ifdef VPPM_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= PREAMBLE;
                        shreg   <= tx.tx_data;
                        pre_cnt <= '0;
                        bit_cnt <= '0;
`ifdef VPPM_PARITY_EN
                        parity  <= 1'b0;
`endif
                    end
                end
                PREAMBLE: begin
                    if (sym_end) begin
                        if (pre_cnt == PRE_LAST) state <= DATA;
                        else                     pre_cnt <= pre_cnt + PRE_W'(1);
                    end
                end
                DATA: begin
                    if (sym_end) begin
`ifdef VPPM_PARITY_EN
                        parity <= parity ^ shreg[DATA_W-1];
`endif
                        if (bit_cnt == BIT_LAST) begin
`ifdef VPPM_PARITY_EN
                            state <= PARITY;
`else
                            state <= GAP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            shreg   <= shreg_shift;
                        end
                    end
                end
                PARITY:  if (sym_end) state <= GAP;
                GAP:     if (sym_end) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    vppm_symbol_gen #(.CNT_W(CNT_W)) u_symbol_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (accept),
        .run        (busy),
        .last       (state == GAP),
        .shape      (shape),
        .period     (symbol_period),
        .width      (pulse_width),
        .line_level (vppm_out),
        .sym_strobe (sym_strobe),
        .sym_end    (sym_end)
    );

endmodule

// File: tb/tb_vppm_modulator_tx.sv
// Scoreboard bench for vppm_modulator_tx: expected frames are queued at issue time, and a
// demodulating monitor checks each frame when busy falls.
module tb_vppm_modulator_tx;

    localparam int PRE = 7;
    localparam int DW  = 8;
`ifdef VPPM_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NSYM = PRE + DW + PAR + 1;

    typedef struct {
        logic [7:0] d;
        int         t;
        int         w;
        int         tc;
        int         wc;
        int         edges;
        int         edges_par;
        bit         par;
        bit         aborted;
        int         idle_before;
    } item_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] symbol_period;
    logic [31:0] pulse_width;
    logic        vppm_out;
    logic        busy;
    logic        sym_strobe;

    int n_checks = 0;
    int n_fail   = 0;
    int stray    = 0;
    item_t exp_q[$];

    vppm_modulator_tx_if #(.DATA_W(DW)) tx_if ();

    vppm_modulator_tx #(.DATA_W(DW), .PREAMBLE_LEN(PRE), .CNT_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .symbol_period (symbol_period),
        .pulse_width   (pulse_width),
        .tx            (tx_if),
        .vppm_out      (vppm_out),
        .busy          (busy),
        .sym_strobe    (sym_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed per frame: clamped T/W, rising edges without and with the parity symbol, and the parity bit.
    item_t vecs[5] = '{
        '{8'hA5, 10,  5, 10, 5, 12, 12, 1'b0, 1'b0, -1},
        '{8'h3C, 10,  0, 10, 1, 14, 15, 1'b0, 1'b0, -1},
        '{8'h3C, 10, 12, 10, 9, 14, 15, 1'b0, 1'b0, -1},
        '{8'h81,  1,  1,  2, 1, 14, 14, 1'b0, 1'b0, -1},
        '{8'h07, 10,  5, 10, 5, 15, 16, 1'b1, 1'b0, -1}
    };

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got no event, expected one within the bound", name);
    endtask

    task automatic wait_accept();
        int n = 0;
        while (tx_if.tx_ready !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (tx_if.tx_ready !== 1'b1) begin
            fail_now("accept_timeout");
            return;
        end
        @(posedge clk);
        #1;
        check("line_high_after_accept", vppm_out, 1);
        check("strobe_after_accept", sym_strobe, 1);
        check("busy_after_accept", busy, 1);
        check("ready_low_after_accept", tx_if.tx_ready, 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b0 && n < 6000);
        if (busy !== 1'b0) fail_now("idle_timeout");
    endtask

    task automatic issue(input item_t it);
        exp_q.push_back(it);
        tx_if.tx_data = it.d;
        symbol_period = it.t;
        pulse_width   = it.w;
        tx_if.tx_valid = 1'b1;
        wait_accept();
        tx_if.tx_valid = 1'b0;
    endtask

    // Monitor: demodulates each frame (data = ~line at every strobe) and scores it when busy falls.
    initial begin : monitor
        bit         in_frame;
        bit         got_abort;
        int         len, edges, pre_edges, highs, strobes, sym, idle_cnt, frame_idle;
        logic [7:0] data;
        logic       prev;
        item_t      e;
`ifdef VPPM_PARITY_EN
        logic       par_got;
        par_got = 1'b0;
`endif
        in_frame = 0; got_abort = 0; idle_cnt = 0; frame_idle = 0;
        len = 0; edges = 0; pre_edges = 0; highs = 0; strobes = 0; sym = 0;
        data = '0; prev = 1'b0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                if (!in_frame) begin
                    in_frame = 1; len = 0; edges = 0; pre_edges = 0; highs = 0;
                    strobes = 0; sym = 0; data = '0; prev = 1'b0; frame_idle = idle_cnt;
                end
                len++;
                if (sym_strobe === 1'b1) begin
                    sym++;
                    strobes++;
                    if (sym > PRE && sym <= PRE + DW) data = {data[6:0], ~vppm_out};
`ifdef VPPM_PARITY_EN
                    if (sym == PRE + DW + 1) par_got = ~vppm_out;
`endif
                end
                if (vppm_out === 1'b1 && prev === 1'b0) begin
                    edges++;
                    if (sym <= PRE) pre_edges++;
                end
                if (vppm_out === 1'b1) highs++;
                prev = vppm_out;
                if (rst_n === 1'b0) got_abort = 1;
            end else begin
                if (in_frame) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_frame");
                    end else begin
                        e = exp_q.pop_front();
                        check("abort_flag", got_abort, e.aborted);
                        if (!e.aborted) begin
                            check("data", data, e.d);
                            check("frame_len", len, NSYM * e.tc);
                            check("high_cycles", highs, (NSYM - 1) * e.wc);
                            check("preamble_edges", pre_edges, PRE);
                            check("rising_edges", edges, (PAR == 1) ? e.edges_par : e.edges);
                            check("strobes", strobes, NSYM);
                            if (e.idle_before >= 0) check("idle_gap", frame_idle, e.idle_before);
`ifdef VPPM_PARITY_EN
                            check("parity", par_got, e.par);
`endif
                        end
                    end
                    in_frame  = 0;
                    got_abort = 0;
                    idle_cnt  = 0;
                end
                idle_cnt++;
                if (rst_n === 1'b1 && (vppm_out !== 1'b0 || sym_strobe !== 1'b0)) stray++;
            end
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1);
    end

    initial begin : stimulus
        item_t it;
        rst_n          = 1'b0;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = '0;
        symbol_period  = 32'd10;
        pulse_width    = 32'd5;

        // tx_valid is held through reset; the word must wait for tx_ready.
        exp_q.push_back(vecs[0]);
        tx_if.tx_data  = vecs[0].d;
        tx_if.tx_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", tx_if.tx_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_line", vppm_out, 0);
        check("reset_strobe", sym_strobe, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("ready_after_reset", tx_if.tx_ready, 1);
        check("busy_after_reset", busy, 0);
        wait_accept();
        tx_if.tx_valid = 1'b0;
        wait_idle();

        for (int i = 1; i < 5; i++) begin
            issue(vecs[i]);
            wait_idle();
        end

        // Reset while data bit 3 is on the line (10 full symbols + 3 cycles at T=10).
        it = '{8'h5A, 10, 5, 10, 5, 0, 0, 1'b0, 1'b1, -1};
        issue(it);
        repeat (103) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("abort_line", vppm_out, 0);
        check("abort_busy", busy, 0);
        check("abort_strobe", sym_strobe, 0);
        check("abort_ready", tx_if.tx_ready, 1);
        it = '{8'hC3, 10, 5, 10, 5, 14, 14, 1'b0, 1'b0, -1};
        issue(it);
        wait_idle();

        // Back-to-back with tx_valid held; T/W change mid-frame must only affect the next frame.
        it = '{8'h00, 20, 5, 20, 5, 15, 16, 1'b0, 1'b0, -1};
        exp_q.push_back(it);
        it = '{8'hFF, 8, 3, 8, 3, 15, 15, 1'b0, 1'b0, 1};
        exp_q.push_back(it);
        tx_if.tx_data  = 8'h00;
        symbol_period  = 32'd20;
        pulse_width    = 32'd5;
        tx_if.tx_valid = 1'b1;
        wait_accept();
        repeat (30) @(posedge clk);
        #1;
        tx_if.tx_data = 8'hFF;
        symbol_period = 32'd8;
        pulse_width   = 32'd3;
        wait_accept();
        tx_if.tx_valid = 1'b0;
        wait_idle();

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("idle_activity", stray, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
